// File: rtl/flow_sram_ctrl.sv
// flow_sram_ctrl: banked flow-state SRAM model with per-port bank occupancy,
// fixed-latency tagged reads and write-first ordering for same-address accesses.
module flow_sram_ctrl #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 64,
  parameter int BANK_BITS    = 1,
  parameter int BANK_CYCLES  = 2,
  parameter int READ_LATENCY = 12,
  parameter int TAG_WIDTH    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic                  write_ready,
  input  logic                  read_en,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [TAG_WIDTH-1:0]  read_tag,
  output logic                  read_ready,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic [TAG_WIDTH-1:0]  read_data_tag,
  output logic                  read_data_valid
);
  localparam int NUM_BANKS = 2 ** BANK_BITS;
  localparam int CW = $clog2(BANK_CYCLES) + 1;
  localparam int PD = READ_LATENCY - 1;
  localparam logic [0:0] INIT = 1'b0;
  localparam logic [0:0] RUN = 1'b1;
  logic [0:0] w_state, r_state;
  logic [CW-1:0] w_busy [NUM_BANKS];
  logic [CW-1:0] r_busy [NUM_BANKS];
  logic [BANK_BITS-1:0] w_bank, r_bank;
  logic w_acc, r_acc;
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic w_pend, r_pend;
  logic [ADDR_WIDTH-1:0] w_addr_q, r_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [TAG_WIDTH-1:0] r_tag_q;
  logic p_vld [PD];
  logic [DATA_WIDTH-1:0] p_data [PD];
  logic [TAG_WIDTH-1:0] p_tag [PD];
  assign w_bank = write_addr[ADDR_WIDTH-1 -: BANK_BITS];
  assign r_bank = read_addr[ADDR_WIDTH-1 -: BANK_BITS];
  assign write_ready = w_state == RUN && w_busy[w_bank] == '0;
  assign read_ready = r_state == RUN && r_busy[r_bank] == '0;
  assign w_acc = write_en && write_ready;
  assign r_acc = read_en && read_ready;
  assign read_data = p_data[PD-1];
  assign read_data_tag = p_tag[PD-1];
  assign read_data_valid = p_vld[PD-1];
  always_ff @(posedge clk) begin
    w_state <= reset ? INIT : RUN;
    r_state <= reset ? INIT : RUN;
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_busy[b] <= reset ? '0 : (w_acc && w_bank == BANK_BITS'(b)) ? CW'(BANK_CYCLES - 1) : w_busy[b] - CW'(w_busy[b] != '0);
      r_busy[b] <= reset ? '0 : (r_acc && r_bank == BANK_BITS'(b)) ? CW'(BANK_CYCLES - 1) : r_busy[b] - CW'(r_busy[b] != '0);
    end
  end
  // accepted writes sit one cycle in w_*_q; reset in that cycle drops the commit
  always_ff @(posedge clk) begin
    w_pend <= !reset && w_acc;
    if (w_acc) begin
      w_addr_q <= write_addr;
      w_data_q <= write_data;
    end
    r_pend <= !reset && r_acc;
    if (r_acc) begin
      r_addr_q <= read_addr;
      r_tag_q <= read_tag;
    end
  end
  always_ff @(posedge clk)
    if (w_pend && !reset) mem[w_addr_q] <= w_data_q;
  // sampling in the commit cycle forwards the committing word (write-first)
  always_ff @(posedge clk) begin
    p_vld[0] <= !reset && r_pend;
    p_data[0] <= (w_pend && w_addr_q == r_addr_q) ? w_data_q : mem[r_addr_q];
    p_tag[0] <= r_tag_q;
    for (int i = 1; i < PD; i++) begin
      p_vld[i] <= !reset && p_vld[i-1];
      p_data[i] <= p_data[i-1];
      p_tag[i] <= p_tag[i-1];
    end
  end
endmodule

// File: tb/tb_flow_sram_ctrl.sv
// tb_flow_sram_ctrl: directed vector table and hand sequences on the default
// configuration, random traffic on a 4-bank configuration, both against a scoreboard.
module tb_flow_sram_ctrl;
  logic clk = 0;
  logic reset = 1;
  always #5 clk = ~clk;
  logic wen [2], ren [2], wrdy [2], rrdy [2], rv [2];
  logic [9:0] wa [2], ra [2];
  logic [63:0] wd [2], rdat [2];
  logic [3:0] rt [2], rtg [2];
  int total = 0, bad = 0;

  flow_sram_ctrl dut0 (
    .clk(clk), .reset(reset),
    .write_en(wen[0]), .write_addr(wa[0]), .write_data(wd[0]), .write_ready(wrdy[0]),
    .read_en(ren[0]), .read_addr(ra[0]), .read_tag(rt[0]), .read_ready(rrdy[0]),
    .read_data(rdat[0]), .read_data_tag(rtg[0]), .read_data_valid(rv[0])
  );

  flow_sram_ctrl #(.ADDR_WIDTH(6), .BANK_BITS(2), .BANK_CYCLES(4), .READ_LATENCY(3)) dut1 (
    .clk(clk), .reset(reset),
    .write_en(wen[1]), .write_addr(wa[1][5:0]), .write_data(wd[1]), .write_ready(wrdy[1]),
    .read_en(ren[1]), .read_addr(ra[1][5:0]), .read_tag(rt[1]), .read_ready(rrdy[1]),
    .read_data(rdat[1]), .read_data_tag(rtg[1]), .read_data_valid(rv[1])
  );

  task automatic chk(string n, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", n, got, exp, $time);
    end
  endtask

  // reference model: spec-level rules per configuration d
  function automatic int bc(int d); return d ? 4 : 2; endfunction
  function automatic int rl(int d); return d ? 3 : 12; endfunction
  function automatic int bk(int d, logic [9:0] a); return d ? int'(a[5:4]) : int'(a[9]); endfunction
  function automatic int am(int d, logic [9:0] a); return d ? int'(a[5:0]) : int'(a); endfunction

  typedef struct { int due; logic [63:0] data; bit kn; logic [3:0] tag; } exp_t;
  exp_t q [2][$];
  logic [63:0] mm [2][1024];
  bit kn [2][1024];
  int lw [2][4], lr [2][4], runc [2], prc [2], pwa [2], pra [2];
  int c = 0, ne = 0;
  bit pw [2], pr [2], xw [2], xr [2];
  logic [63:0] pwd [2];
  logic [3:0] prt [2];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        pw[d] = 0;
        pr[d] = 0;
        q[d].delete();
        runc[d] = 0;
        for (int b = 0; b < 4; b++) begin
          lw[d][b] = -100;
          lr[d][b] = -100;
        end
      end else begin
        if (pw[d]) begin
          mm[d][pwa[d]] = pwd[d];
          kn[d][pwa[d]] = 1;
        end
        if (pr[d]) q[d].push_back('{prc[d] + rl(d), mm[d][pra[d]], kn[d][pra[d]], prt[d]});
        pw[d] = wen[d] && xw[d];
        pr[d] = ren[d] && xr[d];
        if (pw[d]) begin
          pwa[d] = am(d, wa[d]);
          pwd[d] = wd[d];
          lw[d][bk(d, wa[d])] = c;
        end
        if (pr[d]) begin
          pra[d] = am(d, ra[d]);
          prt[d] = rt[d];
          prc[d] = c;
          lr[d][bk(d, ra[d])] = c;
        end
        runc[d]++;
      end
    end
    c++;
    ne++;
  end

  always @(negedge clk) if (ne > 0) for (int d = 0; d < 2; d++) begin
    xw[d] = runc[d] > 0 && c - lw[d][bk(d, wa[d])] >= bc(d);
    xr[d] = runc[d] > 0 && c - lr[d][bk(d, ra[d])] >= bc(d);
    chk($sformatf("write_ready%0d", d), 64'(wrdy[d]), 64'(xw[d]));
    chk($sformatf("read_ready%0d", d), 64'(rrdy[d]), 64'(xr[d]));
    if (q[d].size() > 0 && q[d][0].due == c) begin
      chk($sformatf("valid%0d", d), 64'(rv[d]), 64'd1);
      chk($sformatf("tag%0d", d), 64'(rtg[d]), 64'(q[d][0].tag));
      if (q[d][0].kn) chk($sformatf("data%0d", d), rdat[d], q[d][0].data);
      void'(q[d].pop_front());
    end else chk($sformatf("valid%0d", d), 64'(rv[d]), 64'd0);
  end

  typedef struct { logic [3:0] tag; logic [63:0] data; } cap_t;
  cap_t cap [$];
  int vcnt = 0;
  always @(negedge clk) if (rv[0]) begin
    cap.push_back('{rtg[0], rdat[0]});
    vcnt++;
  end

  typedef struct {
    bit rs, ck, we;
    logic [9:0] wa;
    logic [63:0] wd;
    bit re;
    logic [9:0] ra;
    logic [3:0] rt;
    bit xw, xr;
  } vec_t;

  function automatic vec_t mk(bit rs, bit ck, bit we, logic [9:0] a, logic [63:0] dt,
                              bit re, logic [9:0] r, logic [3:0] t, bit ew, bit er);
    mk = '{rs, ck, we, a, dt, re, r, t, ew, er};
  endfunction

  task automatic drv(int d, bit we, logic [9:0] a, logic [63:0] dt, bit re, logic [9:0] r, logic [3:0] t);
    @(posedge clk);
    #1;
    wen[d] = we; wa[d] = a; wd[d] = dt; ren[d] = re; ra[d] = r; rt[d] = t;
  endtask

  task automatic idle(int d, int n);
    repeat (n) drv(d, 0, 0, 0, 0, 0, 0);
  endtask

  vec_t tv [20];
  int racc, wacc, v0;

  initial begin
    for (int d = 0; d < 2; d++) begin
      wen[d] = 0; ren[d] = 0; wa[d] = 0; ra[d] = 0; wd[d] = 0; rt[d] = 0;
    end
    tv[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tv[1]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tv[2]  = mk(0, 1, 1, 5, 64'hAA, 0, 0, 0, 0, 0);
    tv[3]  = mk(0, 1, 1, 5, 64'hAA, 0, 0, 0, 1, 1);
    tv[4]  = mk(0, 1, 1, 5, 64'hBB, 0, 0, 0, 0, 1);
    tv[5]  = mk(0, 1, 0, 0, 0, 1, 5, 3, 1, 1);
    tv[6]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    tv[7]  = mk(0, 1, 0, 0, 0, 1, 10'h010, 4, 1, 1);
    tv[8]  = mk(0, 1, 0, 0, 0, 1, 10'h011, 5, 1, 0);
    tv[9]  = mk(0, 1, 0, 0, 0, 1, 10'h011, 5, 1, 1);
    tv[10] = mk(0, 1, 0, 0, 0, 1, 10'h210, 6, 1, 1);
    tv[11] = mk(0, 1, 0, 0, 0, 1, 10'h010, 7, 1, 1);
    tv[12] = mk(0, 1, 0, 0, 0, 1, 10'h210, 8, 1, 1);
    tv[13] = mk(0, 1, 0, 0, 0, 1, 10'h010, 9, 1, 1);
    tv[14] = mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    tv[15] = mk(0, 1, 1, 7, 64'h55, 1, 7, 10, 1, 1);
    tv[16] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tv[17] = mk(0, 1, 0, 0, 0, 1, 7, 11, 1, 1);
    tv[18] = mk(0, 1, 1, 7, 64'h66, 0, 0, 0, 1, 0);
    tv[19] = mk(0, 1, 0, 0, 0, 1, 7, 12, 0, 1);
    for (int i = 0; i < 20; i++) begin
      drv(0, tv[i].we, tv[i].wa, tv[i].wd, tv[i].re, tv[i].ra, tv[i].rt);
      reset = tv[i].rs;
      @(negedge clk);
      if (tv[i].ck) begin
        chk($sformatf("vec%0d_write_ready", i), 64'(wrdy[0]), 64'(tv[i].xw));
        chk($sformatf("vec%0d_read_ready", i), 64'(rrdy[0]), 64'(tv[i].xr));
      end
    end
    idle(0, 20);
    chk("vec_result_count", 64'(cap.size()), 64'd10);
    for (int i = 0; i < cap.size(); i++) chk($sformatf("vec_order%0d", i), 64'(cap[i].tag), 64'(i + 3));
    if (cap.size() == 10) begin
      chk("first_read_aa", cap[0].data, 64'hAA);
      chk("same_cycle_55", cap[7].data, 64'h55);
      chk("read_before_write_55", cap[8].data, 64'h55);
      chk("read_after_write_66", cap[9].data, 64'h66);
    end
    // both ports hammer bank 1
    racc = 0;
    wacc = 0;
    v0 = vcnt;
    repeat (40) begin
      drv(0, 1, 10'h200 | 10'($urandom_range(0, 511)), {$urandom, $urandom},
          1, 10'h200 | 10'($urandom_range(0, 511)), 4'($urandom));
      @(negedge clk);
      if (wrdy[0]) wacc++;
      if (rrdy[0]) racc++;
    end
    idle(0, 20);
    chk("hammer_read_accepts", 64'(racc), 64'd20);
    chk("hammer_write_accepts", 64'(wacc), 64'd20);
    chk("hammer_valid_count", 64'(vcnt - v0), 64'(racc));
    // reset with reads in flight and an uncommitted write to addr 9
    drv(0, 1, 10'd9, 64'h99, 0, 0, 0);
    idle(0, 3);
    for (int i = 0; i < 5; i++) drv(0, i == 4, 10'd9, 64'h1234, 1, (i % 2) ? 10'h209 : 10'h009, 4'(i + 1));
    @(posedge clk);
    #1;
    reset = 1;
    wen[0] = 0;
    ren[0] = 0;
    @(posedge clk);
    #1;
    reset = 0;
    v0 = vcnt;
    cap.delete();
    idle(0, 20);
    chk("reset_drops_valids", 64'(vcnt - v0), 64'd0);
    drv(0, 0, 0, 0, 1, 10'd9, 4'hE);
    idle(0, 15);
    chk("post_reset_count", 64'(cap.size()), 64'd1);
    if (cap.size() == 1) begin
      chk("post_reset_tag", 64'(cap[0].tag), 64'hE);
      chk("post_reset_data", cap[0].data, 64'h99);
    end
    // random traffic on the 4-bank configuration
    repeat (3000)
      drv(1, ($urandom % 3) != 0, 10'($urandom_range(0, 63)), {$urandom, $urandom},
          ($urandom % 2) != 0, 10'($urandom_range(0, 63)), 4'($urandom));
    idle(1, 10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
